id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction-decode / operand-fetch stage of the 16-bit, 8-register, 4-stage pipeline (IF, ID, EX, WB).
- Decodes the IF/ID instruction and drives the register-file read addresses. Selects operands from the register file or by forwarding from EX and WB.
- Detects load-use hazards and stalls IF; handles branch flush.
- Owns the ID/EX pipeline register and a saturating stall counter.

Parameters:
- DW, 16, datapath width.
- AW, 3, register address width (8 registers, r0 reads as zero).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_instr  in  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6.
- if_pc  in  16  PC of if_instr.
- flush  in  1  branch taken in EX; squash the ID instruction.
- id_stall  out  1  combinational; IF must hold PC and IF/ID.
- rf_read_addr1  out  3  = rs1, combinational.
- rf_read_data1  in  16  register-file data for addr1.
- rf_read_addr2  out  3  = rs2, combinational.
- rf_read_data2  in  16  register-file data for addr2.
- ex_result  in  16  combinational ALU result of the instruction now in EX.
- wb_wr_en  in  1  WB write enable; same net as the register-file write enable.
- wb_wr_reg  in  3  WB destination.
- wb_wr_data  in  16  WB data.
- idex_valid  out  1  registered.
- idex_opcode  out  4  registered.
- idex_rd  out  3  registered.
- idex_op1  out  16  registered.
- idex_op2  out  16  registered.
- idex_imm  out  16  registered; imm6 sign-extended.
- idex_pc  out  16  registered.
- idex_wr_en  out  1  registered.
- idex_is_load  out  1  registered.
- stall_count  out  16  registered; saturating count of stall cycles.

Behaviour:
- Opcodes:
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LW, 7 SW, 8 BEQ.
  - 0 and 9-15 decode as NOP: no write, no source use.
- Register writes: wr_en=1 for ADD, SUB, AND, OR, ADDI, LW, and only when rd!=0.
- Source use:
  - uses_rs1 for opcodes 1-8.
  - uses_rs2 for 1-4, 7, 8.
  - is_load only for LW.
- Operand select (per source, in priority order):
  - address 0: 0.
  - idex_valid && idex_wr_en && !idex_is_load && idex_rd==addr: ex_result.
  - wb_wr_en && wb_wr_reg==addr && addr!=0: wb_wr_data.
  - otherwise: rf_read_data.
  - Applies whether or not the source is used.
- Load-use hazard:
  - hazard = if_valid && idex_valid && idex_is_load && idex_rd!=0 && ((uses_rs1 && rs1==idex_rd) || (uses_rs2 && rs2==idex_rd)).
  - id_stall = hazard && !flush && !rst.
- Clocked update, in priority order:
  - rst: all idex_* = 0, stall_count = 0.
  - flush: bubble (idex_valid=0, idex_wr_en=0, idex_is_load=0, other idex_* = 0); stall_count unchanged.
  - hazard: bubble; stall_count += 1, saturating at 16'hFFFF.
  - !if_valid: bubble.
  - otherwise: latch decoded fields and selected operands; idex_valid=1.
- Timing:
  - Latency ID to EX is 1 cycle.
  - A stall lasts exactly 1 cycle: next cycle the load is in WB and its data is forwarded from WB.
- Simultaneous events:
  - flush with hazard: flush wins, no stall, counter not incremented.
  - EX and WB match the same register: EX wins.
- rd==0 instructions never forward and never cause a hazard.
- Reset mid-stream: next cycle the ID/EX register is empty and id_stall=0 during the reset cycle.

Test Plan:
1. Reset: assert rst for 2 cycles with if_valid=1, ADD r1,r2,r3 -> all idex_*=0, stall_count=0, id_stall=0.
2. Plain decode: rf_read_data1=16'h0005, rf_read_data2=16'h0003, instr ADD r1,r2,r3 (16'h1298) -> next cycle idex_valid=1, idex_opcode=1, idex_rd=1, idex_op1=5, idex_op2=3, idex_wr_en=1.
3. Forwarding:
   - EX holds ADD r1 with ex_result=16'h00AA, WB writes r1=16'h0011, ID is ADD r4,r1,r1 -> idex_op1=idex_op2=16'h00AA.
   - Repeat with EX rd=r5 -> both operands 16'h0011.
4. Load-use: LW r2 in EX, ID is SUB r3,r2,r0 -> id_stall=1 for one cycle, bubble latched, stall_count=1. Next cycle WB writes r2=16'h1234 -> idex_op1=16'h1234, idex_valid=1.
5. Flush priority: same hazard as scenario 4 plus flush=1 -> id_stall=0, bubble, stall_count unchanged. Separately, ADDI with imm6=6'b111110 -> idex_imm=16'hFFFE.
6. r0 and saturation:
   - EX writes nothing to r0 (rd=0 suppresses wr_en); ID reads r0 -> operand 0, no stall.
   - Force stall_count to 16'hFFFF via 65535 hazards -> stays 16'hFFFF.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode / operand-fetch stage of the 4-stage pipeline.
// Decodes IF/ID, forwards from EX/WB, stalls on load-use, and owns the ID/EX register.
module id_stage #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_valid,
    input  logic [15:0]   if_instr,
    input  logic [DW-1:0] if_pc,
    input  logic          flush,
    output logic          id_stall,
    output logic [AW-1:0] rf_read_addr1,
    input  logic [DW-1:0] rf_read_data1,
    output logic [AW-1:0] rf_read_addr2,
    input  logic [DW-1:0] rf_read_data2,
    input  logic [DW-1:0] ex_result,
    input  logic          wb_wr_en,
    input  logic [AW-1:0] wb_wr_reg,
    input  logic [DW-1:0] wb_wr_data,
    output logic          idex_valid,
    output logic [3:0]    idex_opcode,
    output logic [AW-1:0] idex_rd,
    output logic [DW-1:0] idex_op1,
    output logic [DW-1:0] idex_op2,
    output logic [DW-1:0] idex_imm,
    output logic [DW-1:0] idex_pc,
    output logic          idex_wr_en,
    output logic          idex_is_load,
    output logic [15:0]   stall_count
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8
    } opcode_e;

    logic [3:0]    opcode;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [5:0]    imm6;
    logic          uses_rs1;
    logic          uses_rs2;
    logic          writes_rd;
    logic          is_load;
    logic          wr_en;
    logic          ex_fwd_ok;
    logic          hazard;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;

    assign opcode = if_instr[15:12];
    assign rd     = if_instr[11:9];
    assign rs1    = if_instr[8:6];
    assign rs2    = if_instr[5:3];
    assign imm6   = if_instr[5:0];

    assign rf_read_addr1 = rs1;
    assign rf_read_addr2 = rs2;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_ADDI: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_LW: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    // Writes to r0 are dropped at decode, so r0 can never be a forwarding or hazard source.
    assign wr_en = writes_rd && (rd != '0);

    // A load in EX has no result yet; its data only becomes forwardable from WB.
    assign ex_fwd_ok = idex_valid && idex_wr_en && !idex_is_load;

    function automatic logic [DW-1:0] select_operand(
        input logic [AW-1:0] addr,
        input logic [DW-1:0] rf_data,
        input logic          ex_ok,
        input logic [AW-1:0] ex_rd,
        input logic [DW-1:0] ex_data,
        input logic          wb_en,
        input logic [AW-1:0] wb_reg,
        input logic [DW-1:0] wb_data
    );
        if (addr == '0)
            return '0;
        else if (ex_ok && ex_rd == addr)
            return ex_data;
        else if (wb_en && wb_reg == addr)
            return wb_data;
        else
            return rf_data;
    endfunction

    assign op1 = select_operand(rs1, rf_read_data1, ex_fwd_ok, idex_rd, ex_result,
                                wb_wr_en, wb_wr_reg, wb_wr_data);
    assign op2 = select_operand(rs2, rf_read_data2, ex_fwd_ok, idex_rd, ex_result,
                                wb_wr_en, wb_wr_reg, wb_wr_data);

    assign hazard = if_valid && idex_valid && idex_is_load && (idex_rd != '0) &&
                    ((uses_rs1 && rs1 == idex_rd) || (uses_rs2 && rs2 == idex_rd));

    assign id_stall = hazard && !flush && !rst;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush || hazard || !if_valid) begin
            idex_valid   <= 1'b0;
            idex_opcode  <= '0;
            idex_rd      <= '0;
            idex_op1     <= '0;
            idex_op2     <= '0;
            idex_imm     <= '0;
            idex_pc      <= '0;
            idex_wr_en   <= 1'b0;
            idex_is_load <= 1'b0;
        end else begin
            idex_valid   <= 1'b1;
            idex_opcode  <= opcode;
            idex_rd      <= rd;
            idex_op1     <= op1;
            idex_op2     <= op2;
            idex_imm     <= {{(DW-6){imm6[5]}}, imm6};
            idex_pc      <= if_pc;
            idex_wr_en   <= wr_en;
            idex_is_load <= is_load;
        end

        // Only a real stall (not one cancelled by flush or reset) is counted.
        if (rst)
            stall_count <= '0;
        else if (!flush && hazard && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end

endmodule
